// File: rtl/qc_pkg.sv
// Shared Q2.16 complex fixed-point types, constants and the accumulator FSM states.
package qc_pkg;

  localparam int FIX_W  = 19;
  localparam int FRAC_W = 16;
  localparam logic signed [FIX_W-1:0] FIX_ONE = 19'sh10000;

  typedef logic signed [FIX_W-1:0] cfix_t;
  // Indexed [row][col][0=re,1=im]
  typedef cfix_t [0:1][0:1][0:1] cmtx_t;

  localparam cmtx_t IDENTITY = '{
    '{'{FIX_ONE, 19'sd0}, '{19'sd0, 19'sd0}},
    '{'{19'sd0, 19'sd0}, '{FIX_ONE, 19'sd0}}
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } gsa_state_t;

  // Full-precision Q4.32 product, widened so four of them can be summed without overflow
  function automatic logic signed [39:0] fix_prod(cfix_t a, cfix_t b);
    logic signed [39:0] ae;
    logic signed [39:0] be;
    ae = 40'(a);
    be = 40'(b);
    return ae * be;
  endfunction

  // Back to Q2.16: floor shift, then wrap into 19 bits
  function automatic cfix_t fix_trunc(logic signed [39:0] acc);
    return cfix_t'(acc >>> FRAC_W);
  endfunction

endpackage

// File: rtl/gate_sequence_accumulator_if.sv
// Gate-stream and result bus of the gate sequence accumulator.
interface gate_sequence_accumulator_if
  import qc_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic             seq_start;
  logic             gate_valid;
  logic             gate_last;
  cmtx_t            gate_in;
  logic             gate_ready;
  cmtx_t            result;
  logic             result_valid;
  logic             busy;
  logic [CNT_W-1:0] gate_count;

  modport slave (
    input  seq_start, gate_valid, gate_last, gate_in,
    output gate_ready, result, result_valid, busy, gate_count
  );

  modport master (
    output seq_start, gate_valid, gate_last, gate_in,
    input  gate_ready, result, result_valid, busy, gate_count
  );

endinterface

// File: rtl/complex_matrix_multiplier.sv
// 2x2 complex Q2.16 matrix product R = A x B: inputs captured on ready, completed pulses one edge later.
module complex_matrix_multiplier
  import qc_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  ready,
  input  cmtx_t mtx_a,
  input  cmtx_t mtx_b,
  output logic  completed,
  output cmtx_t mtx_r
);

  cmtx_t a_reg;
  cmtx_t b_reg;
  cmtx_t prod;
  cmtx_t r_reg;
  logic  pending_reg;
  logic  completed_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_row
      for (genvar gj = 0; gj < 2; gj++) begin : g_col
        logic signed [39:0] re_acc;
        logic signed [39:0] im_acc;
        assign re_acc = fix_prod(a_reg[gi][0][0], b_reg[0][gj][0])
                      - fix_prod(a_reg[gi][0][1], b_reg[0][gj][1])
                      + fix_prod(a_reg[gi][1][0], b_reg[1][gj][0])
                      - fix_prod(a_reg[gi][1][1], b_reg[1][gj][1]);
        assign im_acc = fix_prod(a_reg[gi][0][0], b_reg[0][gj][1])
                      + fix_prod(a_reg[gi][0][1], b_reg[0][gj][0])
                      + fix_prod(a_reg[gi][1][0], b_reg[1][gj][1])
                      + fix_prod(a_reg[gi][1][1], b_reg[1][gj][0]);
        assign prod[gi][gj][0] = fix_trunc(re_acc);
        assign prod[gi][gj][1] = fix_trunc(im_acc);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg         <= '0;
      b_reg         <= '0;
      r_reg         <= '0;
      pending_reg   <= 1'b0;
      completed_reg <= 1'b0;
    end else begin
      pending_reg   <= ready;
      completed_reg <= pending_reg;
      if (ready) begin
        a_reg <= mtx_a;
        b_reg <= mtx_b;
      end
      if (pending_reg) begin
        r_reg <= prod;
      end
    end
  end

  assign completed = completed_reg;
  assign mtx_r     = r_reg;

endmodule

// File: rtl/gate_sequence_accumulator.sv
// Folds a stream of 2x2 complex gates into a running unitary U <= G x U.
module gate_sequence_accumulator
  import qc_pkg::*;
#(
  parameter int CNT_W = 8
)(
  input logic clk,
  input logic reset,
  gate_sequence_accumulator_if.slave bus
);

  gsa_state_t       state_reg;
  cmtx_t            u_reg;
  cmtx_t            g_reg;
  cmtx_t            mtx_r;
  logic             last_reg;
  logic             gate_ready_reg;
  logic             busy_reg;
  logic             result_valid_reg;
  logic             mul_ready_reg;
  logic             completed;
  logic [CNT_W-1:0] count_reg;

  // g_reg and u_reg stay untouched from ISSUE until the product returns
  complex_matrix_multiplier u_mul (
    .clk       (clk),
    .reset     (reset),
    .ready     (mul_ready_reg),
    .mtx_a     (g_reg),
    .mtx_b     (u_reg),
    .completed (completed),
    .mtx_r     (mtx_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      u_reg            <= IDENTITY;
      g_reg            <= '0;
      last_reg         <= 1'b0;
      count_reg        <= '0;
      gate_ready_reg   <= 1'b0;
      busy_reg         <= 1'b0;
      result_valid_reg <= 1'b0;
      mul_ready_reg    <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      mul_ready_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (bus.seq_start) begin
            u_reg          <= IDENTITY;
            count_reg      <= '0;
            gate_ready_reg <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.gate_valid) begin
            g_reg          <= bus.gate_in;
            last_reg       <= bus.gate_last;
            gate_ready_reg <= 1'b0;
            mul_ready_reg  <= 1'b1;
            state_reg      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (completed) begin
            u_reg <= mtx_r;
            if (count_reg != {CNT_W{1'b1}}) begin
              count_reg <= count_reg + 1'b1;
            end
            if (last_reg) begin
              result_valid_reg <= 1'b1;
              busy_reg         <= 1'b0;
              state_reg        <= ST_DONE;
            end else begin
              gate_ready_reg <= 1'b1;
              state_reg      <= ST_LOAD;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gate_ready   = gate_ready_reg;
  assign bus.result       = u_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.busy         = busy_reg;
  assign bus.gate_count   = count_reg;

endmodule

// File: tb/tb_gate_sequence_accumulator.sv
// Randomized bench for gate_sequence_accumulator against a cycle-level matrix-product reference model.
module tb_gate_sequence_accumulator;
  import qc_pkg::*;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_BUSY  = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gate_sequence_accumulator_if #(.CNT_W(CNT_W)) bus ();

  gate_sequence_accumulator #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int pulses     = 0;
  int pulse_cyc  = -1;
  int accept_cyc = -1;

  int    m_phase = P_IDLE;
  int    m_left  = 0;
  int    m_cnt   = 0;
  cmtx_t m_u     = IDENTITY;
  cmtx_t m_g     = '0;
  logic  m_last  = 1'b0;
  logic  m_rv    = 1'b0;
  logic  m_acc   = 1'b0;

  cmtx_t px;
  cmtx_t ii;
  cmtx_t neg_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Plain complex matrix product in Q2.16 with floor rounding and 19-bit wrap
  function automatic cmtx_t mat_mul(input cmtx_t a, input cmtx_t b);
    cmtx_t r;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        longint re = 0;
        longint im = 0;
        for (int k = 0; k < 2; k++) begin
          longint ar = longint'(a[i][k][0]);
          longint ai = longint'(a[i][k][1]);
          longint br = longint'(b[k][j][0]);
          longint bi = longint'(b[k][j][1]);
          re += ar * br - ai * bi;
          im += ar * bi + ai * br;
        end
        r[i][j][0] = cfix_t'(re >>> 16);
        r[i][j][1] = cfix_t'(im >>> 16);
      end
    end
    return r;
  endfunction

  function automatic cmtx_t rand_mtx();
    cmtx_t r;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int c = 0; c < 2; c++)
          r[i][j][c] = cfix_t'($urandom);
    return r;
  endfunction

  // Advance the reference by one clock edge given the inputs currently driven
  task automatic model_edge();
    m_acc = 1'b0;
    m_rv  = 1'b0;
    if (reset) begin
      m_phase = P_IDLE;
      m_u     = IDENTITY;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: begin
          if (bus.seq_start) begin
            m_u     = IDENTITY;
            m_cnt   = 0;
            m_phase = P_LOAD;
          end
        end
        P_LOAD: begin
          if (bus.gate_valid) begin
            m_g     = bus.gate_in;
            m_last  = bus.gate_last;
            m_left  = 3;
            m_acc   = 1'b1;
            m_phase = P_BUSY;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_u = mat_mul(m_g, m_u);
            if (m_cnt < CNT_MAX) m_cnt++;
            m_rv    = m_last;
            m_phase = m_last ? P_DONE : P_LOAD;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    if (m_acc) accept_cyc = cyc;
    if (bus.result_valid) begin
      pulses++;
      pulse_cyc = cyc;
    end
    check("gate_ready", 128'(bus.gate_ready), 128'(m_phase == P_LOAD));
    check("busy", 128'(bus.busy), 128'(m_phase == P_LOAD || m_phase == P_BUSY));
    check("result_valid", 128'(bus.result_valid), 128'(m_rv));
    check("gate_count", 128'(bus.gate_count), 128'(m_cnt));
    check("result", 128'(bus.result), 128'(m_u));
  endtask

  task automatic start_seq();
    bus.seq_start = 1'b1;
    step();
    bus.seq_start = 1'b0;
  endtask

  task automatic send_gate(input cmtx_t g, input logic last, input int gap);
    logic got;
    got = 1'b0;
    repeat (gap) step();
    bus.gate_valid = 1'b1;
    bus.gate_in    = g;
    bus.gate_last  = last;
    for (int t = 0; t < 20 && !got; t++) begin
      step();
      got = m_acc;
    end
    if (!got) check("accept_timeout", 128'(0), 128'(1));
    bus.gate_valid = 1'b0;
    bus.gate_last  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    int idx;
    int acc_c[3];
    cmtx_t gates[3];

    px = '0;
    px[0][1][0] = FIX_ONE;
    px[1][0][0] = FIX_ONE;
    ii = '0;
    ii[0][0][1] = FIX_ONE;
    ii[1][1][1] = FIX_ONE;
    neg_i = '0;
    neg_i[0][0][0] = 19'sh70000;
    neg_i[1][1][0] = 19'sh70000;

    bus.seq_start  = 1'b0;
    bus.gate_valid = 1'b0;
    bus.gate_last  = 1'b0;
    bus.gate_in    = '0;

    // Reset held for three cycles
    reset = 1'b1;
    repeat (3) step();
    check("rst_result", 128'(bus.result), 128'(IDENTITY));
    check("rst_gate_ready", 128'(bus.gate_ready), 128'(0));
    check("rst_count", 128'(bus.gate_count), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    reset = 1'b0;
    step();

    // Pauli-X squared
    start_seq();
    send_gate(px, 1'b0, 0);
    p0 = pulses;
    send_gate(px, 1'b1, 1);
    repeat (5) step();
    check("x2_result", 128'(bus.result), 128'(IDENTITY));
    check("x2_count", 128'(bus.gate_count), 128'(2));
    check("x2_pulses", 128'(pulses - p0), 128'(1));
    check("x2_latency", 128'(pulse_cyc - accept_cyc), 128'(3));

    // iI twice gives -I
    start_seq();
    send_gate(ii, 1'b0, 0);
    send_gate(ii, 1'b1, 0);
    repeat (4) step();
    check("ii2_result", 128'(bus.result), 128'(neg_i));

    // gate_valid held high across a three-gate sequence
    start_seq();
    for (int g = 0; g < 3; g++) gates[g] = rand_mtx();
    idx = 0;
    bus.gate_valid = 1'b1;
    bus.gate_in    = gates[0];
    bus.gate_last  = 1'b0;
    for (int t = 0; t < 40 && idx < 3; t++) begin
      step();
      if (m_acc) begin
        acc_c[idx] = cyc;
        idx++;
        if (idx < 3) begin
          bus.gate_in   = gates[idx];
          bus.gate_last = (idx == 2);
        end
      end
    end
    bus.gate_valid = 1'b0;
    bus.gate_last  = 1'b0;
    check("bp_accepts", 128'(idx), 128'(3));
    check("bp_space01", 128'(acc_c[1] - acc_c[0]), 128'(4));
    check("bp_space12", 128'(acc_c[2] - acc_c[1]), 128'(4));
    repeat (4) step();

    // seq_start during WAIT is ignored
    start_seq();
    send_gate(rand_mtx(), 1'b0, 0);
    step();
    bus.seq_start = 1'b1;
    step();
    bus.seq_start = 1'b0;
    send_gate(rand_mtx(), 1'b1, 0);
    repeat (4) step();
    check("wait_start_count", 128'(bus.gate_count), 128'(2));

    // seq_start together with gate_valid in DONE: start wins
    bus.seq_start  = 1'b1;
    bus.gate_valid = 1'b1;
    bus.gate_in    = rand_mtx();
    bus.gate_last  = 1'b1;
    step();
    bus.seq_start  = 1'b0;
    bus.gate_valid = 1'b0;
    bus.gate_last  = 1'b0;
    check("done_start_result", 128'(bus.result), 128'(IDENTITY));
    check("done_start_ready", 128'(bus.gate_ready), 128'(1));
    check("done_start_count", 128'(bus.gate_count), 128'(0));
    send_gate(rand_mtx(), 1'b1, 0);
    repeat (4) step();

    // Reset while the product is in flight
    start_seq();
    send_gate(rand_mtx(), 1'b1, 0);
    step();
    step();
    p0 = pulses;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_result", 128'(bus.result), 128'(IDENTITY));
    check("midrst_busy", 128'(bus.busy), 128'(0));
    check("midrst_ready", 128'(bus.gate_ready), 128'(0));
    repeat (6) step();
    check("midrst_pulses", 128'(pulses - p0), 128'(0));

    // Random sequences with random gaps
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(1, 5);
      start_seq();
      for (int g = 0; g < n; g++) send_gate(rand_mtx(), g == n - 1, $urandom_range(0, 3));
      repeat (4) step();
      check("rand_count", 128'(bus.gate_count), 128'(n));
    end

    // Gate counter saturation
    start_seq();
    for (int g = 0; g < 258; g++) send_gate(rand_mtx(), g == 257, 0);
    repeat (4) step();
    check("sat_count", 128'(bus.gate_count), 128'(CNT_MAX));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
